conv_engine_n: RTL and testbench
================================

Name: conv_engine_n

Overview:
- Parametrised single-layer convolution engine with on-chip image and weight buffers and a start/done handshake.
- Slides a K x K window over an IMG x IMG input, stride 1, no padding. N filters are evaluated in parallel, so N MACs run per cycle.
- Streams one packed N-channel result per window position.
- Generalises the fixed 8x8 / 4x4 / N-filter layer datapath-plus-controller pair into one parametrised block with an internal FSM.

Parameters:
- N, 2, number of parallel filters/output channels (>=1)
- DW, 9, signed data/weight width in bits
- IMG, 8, input image side length
- K, 4, kernel side length (1 <= K <= IMG)

Derived constants (localparam):
- OS = IMG-K+1
- KK = K*K
- AW = 2*DW + clog2(KK)
- XA = clog2(IMG*IMG)
- WA = clog2(N*KK)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin one layer pass; sampled only in IDLE
- x_we  in  1  image buffer write enable
- x_addr  in  XA  image address = row*IMG+col
- x_data  in  DW  signed pixel
- w_we  in  1  weight buffer write enable
- w_addr  in  WA  weight address = f*KK + kr*K + kc
- w_data  in  DW  signed weight
- busy  out  1  high in CALC/EMIT/DONE
- out_valid  out  1  one-cycle pulse per window
- out_row  out  clog2(OS)  window row of current result
- out_col  out  clog2(OS)  window col of current result
- out_data  out  N*AW  packed results; filter f occupies bits [f*AW +: AW], signed
- done  out  1  one-cycle pulse after last window

Behaviour:
- Reset (rst=1 at an edge):
  - state to IDLE; counters, accumulators, out_* and done all cleared to 0; busy=0.
  - Buffer contents are not reset. rst mid-operation aborts the pass immediately; no done pulse.
- Buffers:
  - Register arrays with asynchronous read and synchronous write.
  - Writes are accepted only in IDLE; x_we/w_we are ignored while busy.
  - Out-of-range addresses are ignored.
- FSM states: IDLE -> CALC -> EMIT -> (CALC | DONE) -> IDLE.
  - IDLE: start=1 leads to CALC with k=0, window (0,0), all N accumulators cleared.
  - CALC: each cycle, for every f, acc[f] += x[(r+kr)*IMG + (c+kc)] * w[f*KK+k], with kr=k/K and kc=k%K (row-major kernel walk).
    - k increments each cycle; after the k=KK-1 update the FSM goes to EMIT.
    - CALC lasts exactly KK cycles.
  - EMIT: out_valid=1 for one cycle, out_data = acc, out_row=r, out_col=c.
    - Then advance the window column-major-inner: c++, and wrap to c=0 with r++ at c=OS-1.
    - If the window was (OS-1, OS-1), go to DONE. Otherwise go to CALC with k=0 and the accumulators cleared.
  - DONE: done=1 for one cycle, then IDLE.
- Timing: with start sampled at the edge ending cycle t:
  - first out_valid in cycle t+KK+1;
  - window period is KK+1 cycles;
  - done in cycle t + OS*OS*(KK+1) + 1.
- Control-input edge cases:
  - start while busy is ignored.
  - start and x_we/w_we asserted together in IDLE: the write completes, and CALC reads the new value.
  - A held start re-triggers one cycle after DONE, i.e. back-to-back passes.
- Arithmetic:
  - Full-precision signed products (2*DW bits), sign-extended into AW-bit accumulators. AW guarantees no overflow.
  - out_row, out_col and out_data hold their value between EMIT cycles.

Optional Feature:
- Macro: CONV_ENGINE_RELU_EN.
- Defined: each channel of out_data is clamped at EMIT. A negative accumulator is output as 0; the accumulator itself is not modified.
- Undefined: raw signed accumulator values are output. Timing is identical in both builds.

Test Plan:
- Defaults; all 64 pixels=1, all 32 weights=1; pulse start -> 25 out_valid pulses, each channel = 16, rows/cols stepping (0,0)..(4,4), done at cycle t+426, busy low the cycle after.
- Pixel(r,c)=r*8+c; filter0 weights all 1, filter1 single 1 at k=0 -> window (0,0): ch0=216, ch1=0; window (4,4): ch0=792, ch1=36.
- Pixels all -256, weights all -256 -> each channel = 1048576 (no overflow at AW=22); weights +255 -> -1044480, or 0 with CONV_ENGINE_RELU_EN.
- rst asserted during 3rd window CALC -> next cycle out_* = 0, busy=0, no done. A fresh start reproduces the scenario-1 results from the unchanged buffers.
- start pulsed again and x_we/w_we asserted mid-pass -> no restart, buffers unchanged, results identical to scenario 1.
- Params N=1, IMG=4, K=4 -> exactly one out_valid at cycle t+17, done at t+18.

Source files
------------

// File: rtl/conv_engine_n.sv
// conv_engine_n: K x K stride-1 convolution over an IMG x IMG image, N filters in parallel,
// one MAC per filter per cycle, start/done handshake. Ports: clk, rst (sync, active-high),
// start; x_we/x_addr/x_data image write; w_we/w_addr/w_data weight write; busy, out_valid,
// out_row, out_col, out_data (N packed signed AW-bit channels), done.
// Optional macro CONV_ENGINE_RELU_EN clamps negative channels to 0 at output.
module conv_engine_n #(
  parameter int N   = 2,
  parameter int DW  = 9,
  parameter int IMG = 8,
  parameter int K   = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic                                        x_we,
  input  logic [$clog2(IMG*IMG)-1:0]                  x_addr,
  input  logic signed [DW-1:0]                        x_data,
  input  logic                                        w_we,
  input  logic [$clog2(N*K*K)-1:0]                    w_addr,
  input  logic signed [DW-1:0]                        w_data,
  output logic                                        busy,
  output logic                                        out_valid,
  output logic [((IMG-K+1) > 1 ? $clog2(IMG-K+1) : 1)-1:0] out_row,
  output logic [((IMG-K+1) > 1 ? $clog2(IMG-K+1) : 1)-1:0] out_col,
  output logic [N*(2*DW+$clog2(K*K))-1:0]             out_data,
  output logic                                        done
);

  localparam int OS = IMG - K + 1;
  localparam int KK = K * K;
  localparam int AW = 2 * DW + $clog2(KK);
  localparam int XA = $clog2(IMG * IMG);
  localparam int WA = $clog2(N * KK);
  localparam int RW = (OS > 1) ? $clog2(OS) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    S_IDLE, S_CALC, S_EMIT, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [KW-1:0] kr_q, kr_d, kc_q, kc_d;
  logic [RW-1:0] r_q, r_d, c_q, c_d;
  logic signed [AW-1:0] acc_q [N];
  logic signed [AW-1:0] acc_d [N];
  logic out_valid_q, out_valid_d, done_q, done_d, busy_q, busy_d;
  logic [RW-1:0] out_row_q, out_row_d, out_col_q, out_col_d;
  logic [N*AW-1:0] out_data_q, out_data_d;

  logic signed [DW-1:0] x_mem_q [IMG*IMG];
  logic signed [DW-1:0] w_mem_q [N*KK];

  logic [XA-1:0] x_idx;
  logic signed [2*DW-1:0] prod;
  int kofs;

  // Buffers load only while idle so a running pass sees stable data.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && x_we && int'(x_addr) < IMG * IMG)
      x_mem_q[x_addr] <= x_data;
    if (state_q == S_IDLE && w_we && int'(w_addr) < N * KK)
      w_mem_q[w_addr] <= w_data;
  end

  always_comb begin
    state_d     = state_q;
    kr_d        = kr_q;
    kc_d        = kc_q;
    r_d         = r_q;
    c_d         = c_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    out_data_d  = out_data_q;
    prod        = '0;
    kofs        = int'(kr_q) * K + int'(kc_q);
    x_idx       = XA'((int'(r_q) + int'(kr_q)) * IMG + int'(c_q) + int'(kc_q));
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CALC;
          kr_d    = '0;
          kc_d    = '0;
          r_d     = '0;
          c_d     = '0;
          for (int f = 0; f < N; f++) acc_d[f] = '0;
        end
      end
      S_CALC: begin
        for (int f = 0; f < N; f++) begin
          prod     = x_mem_q[x_idx] * w_mem_q[WA'(f * KK + kofs)];
          acc_d[f] = acc_q[f] + AW'(prod);
        end
        if (int'(kc_q) == K - 1) begin
          kc_d = '0;
          if (int'(kr_q) == K - 1) begin
            // Last tap: publish the final sums so out_valid lines up with EMIT.
            state_d     = S_EMIT;
            out_valid_d = 1'b1;
            out_row_d   = r_q;
            out_col_d   = c_q;
            for (int f = 0; f < N; f++) begin
`ifdef CONV_ENGINE_RELU_EN
              out_data_d[f*AW +: AW] = acc_d[f][AW-1] ? '0 : acc_d[f];
`else
              out_data_d[f*AW +: AW] = acc_d[f];
`endif
            end
          end else begin
            kr_d = kr_q + KW'(1);
          end
        end else begin
          kc_d = kc_q + KW'(1);
        end
      end
      S_EMIT: begin
        if (int'(r_q) == OS - 1 && int'(c_q) == OS - 1) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_CALC;
          kr_d    = '0;
          kc_d    = '0;
          for (int f = 0; f < N; f++) acc_d[f] = '0;
          if (int'(c_q) == OS - 1) begin
            c_d = '0;
            r_d = r_q + RW'(1);
          end else begin
            c_d = c_q + RW'(1);
          end
        end
      end
      S_DONE: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      kr_q        <= '0;
      kc_q        <= '0;
      r_q         <= '0;
      c_q         <= '0;
      acc_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      kr_q        <= kr_d;
      kc_q        <= kc_d;
      r_q         <= r_d;
      c_q         <= c_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_data_q  <= out_data_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_data  = out_data_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv_engine_n.sv
// tb_conv_engine_n: directed bench for conv_engine_n, default build plus a
// 4x4-image / 4x4-kernel / single-filter instance.
module tb_conv_engine_n;

  localparam int AW = 22;

  logic clk = 1'b0;
  logic rst, start, x_we, w_we;
  logic [5:0] x_addr;
  logic [4:0] w_addr;
  logic signed [8:0] x_data, w_data;
  logic busy, out_valid, done;
  logic [2:0] out_row, out_col;
  logic [2*AW-1:0] out_data;

  logic s_start, s_x_we, s_w_we;
  logic [3:0] s_x_addr, s_w_addr;
  logic signed [8:0] s_x_data, s_w_data;
  logic s_busy, s_out_valid, s_done;
  logic [0:0] s_out_row, s_out_col;
  logic [AW-1:0] s_out_data;

  int errors = 0;
  int checks = 0;

  int vcnt, done_off, hold_bad;
  logic busy_first, busy_after;
  int vd [25];
  int vr [25];
  int vc [25];
  logic signed [AW-1:0] r0 [25];
  logic signed [AW-1:0] r1 [25];

  always #5 clk = ~clk;

  conv_engine_n dut (
    .clk(clk), .rst(rst), .start(start),
    .x_we(x_we), .x_addr(x_addr), .x_data(x_data),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .busy(busy), .out_valid(out_valid), .out_row(out_row),
    .out_col(out_col), .out_data(out_data), .done(done)
  );

  conv_engine_n #(.N(1), .DW(9), .IMG(4), .K(4)) dut_s (
    .clk(clk), .rst(rst), .start(s_start),
    .x_we(s_x_we), .x_addr(s_x_addr), .x_data(s_x_data),
    .w_we(s_w_we), .w_addr(s_w_addr), .w_data(s_w_data),
    .busy(s_busy), .out_valid(s_out_valid), .out_row(s_out_row),
    .out_col(s_out_col), .out_data(s_out_data), .done(s_done)
  );

  task automatic load_x(input int mode);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      x_we = 1'b1;
      x_addr = 6'(i);
      if (mode == 0) x_data = 9'sd1;
      else if (mode == 1) x_data = 9'(i);
      else x_data = 9'h100;
    end
    @(negedge clk);
    x_we = 1'b0;
  endtask

  task automatic load_w(input int mode);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      w_we = 1'b1;
      w_addr = 5'(i);
      if (mode == 0) w_data = 9'sd1;
      else if (mode == 1) w_data = (i < 16 || i == 16) ? 9'sd1 : 9'sd0;
      else if (mode == 2) w_data = 9'h100;
      else w_data = 9'sd255;
    end
    @(negedge clk);
    w_we = 1'b0;
  endtask

  // mode 0: plain; 1: start/writes pulsed mid-pass; 2: write x[0]=5 with start.
  task automatic run_pass(input int mode);
    logic [2*AW-1:0] last;
    last = '0;
    vcnt = 0;
    done_off = -1;
    hold_bad = 0;
    busy_first = 1'b0;
    @(negedge clk);
    start = 1'b1;
    if (mode == 2) begin
      x_we = 1'b1; x_addr = 6'd0; x_data = 9'sd5;
    end
    for (int d = 1; d <= 1000 && done_off < 0; d++) begin
      @(negedge clk);
      if (d == 1) begin
        start = 1'b0; x_we = 1'b0; busy_first = busy;
      end
      if (mode == 1 && (d == 5 || d == 200)) begin
        start = 1'b1; x_we = 1'b1; x_addr = 6'd0; x_data = -9'sd5;
        w_we = 1'b1; w_addr = 5'd0; w_data = -9'sd7;
      end
      if (mode == 1 && (d == 6 || d == 201)) begin
        start = 1'b0; x_we = 1'b0; w_we = 1'b0;
      end
      if (out_valid) begin
        if (vcnt < 25) begin
          vd[vcnt] = d; vr[vcnt] = int'(out_row); vc[vcnt] = int'(out_col);
          r0[vcnt] = out_data[AW-1:0]; r1[vcnt] = out_data[2*AW-1:AW];
        end
        vcnt++;
        last = out_data;
      end else if (vcnt > 0 && out_data !== last) begin
        hold_bad++;
      end
      if (done) done_off = d;
    end
    @(negedge clk);
    busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; x_we = 0; w_we = 0;
    x_addr = '0; w_addr = '0; x_data = '0; w_data = '0;
    s_start = 0; s_x_we = 0; s_w_we = 0;
    s_x_addr = '0; s_w_addr = '0; s_x_data = '0; s_w_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl busy=%b valid=%b done=%b want 0 0 0", busy, out_valid, done);
    end
    checks++;
    if (out_data !== '0 || out_row !== '0 || out_col !== '0) begin
      errors++; $display("FAIL reset_out data=%h row=%0d col=%0d want 0", out_data, out_row, out_col);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ones();
    int tb, ob, vb;
    load_x(0);
    load_w(0);
    run_pass(0);
    tb = 0; ob = 0; vb = 0;
    for (int i = 0; i < 25; i++) begin
      if (vd[i] != 17 * (i + 1)) tb++;
      if (vr[i] != i / 5 || vc[i] != i % 5) ob++;
      if (r0[i] !== 22'sd16 || r1[i] !== 22'sd16) vb++;
    end
    checks++;
    if (vcnt != 25) begin errors++; $display("FAIL ones_count got=%0d want=25", vcnt); end
    checks++;
    if (vd[0] != 17) begin errors++; $display("FAIL ones_first got=%0d want=17", vd[0]); end
    checks++;
    if (tb != 0) begin errors++; $display("FAIL ones_period bad=%0d want=0", tb); end
    checks++;
    if (ob != 0) begin errors++; $display("FAIL ones_order bad=%0d want=0", ob); end
    checks++;
    if (vb != 0) begin errors++; $display("FAIL ones_value bad=%0d want=0 (ch0=%0d)", vb, r0[0]); end
    checks++;
    if (hold_bad != 0) begin errors++; $display("FAIL ones_hold bad=%0d want=0", hold_bad); end
    checks++;
    if (done_off != 426) begin errors++; $display("FAIL ones_done got=%0d want=426", done_off); end
    checks++;
    if (busy_first !== 1'b1 || busy_after !== 1'b0) begin
      errors++; $display("FAIL ones_busy got=%b%b want=10", busy_first, busy_after);
    end
  endtask

  task automatic test_midpass();
    int vb;
    run_pass(1);
    vb = 0;
    for (int i = 0; i < 25; i++)
      if (r0[i] !== 22'sd16 || r1[i] !== 22'sd16) vb++;
    checks++;
    if (vcnt != 25 || done_off != 426) begin
      errors++; $display("FAIL mid_timing cnt=%0d done=%0d want 25 426", vcnt, done_off);
    end
    checks++;
    if (vb != 0) begin errors++; $display("FAIL mid_value bad=%0d want=0 (ch0=%0d)", vb, r0[0]); end
  endtask

  task automatic test_start_write();
    run_pass(2);
    checks++;
    if (r0[0] !== 22'sd20 || r1[0] !== 22'sd20) begin
      errors++; $display("FAIL sw_win0 got=%0d,%0d want=20,20", r0[0], r1[0]);
    end
    checks++;
    if (r0[1] !== 22'sd16) begin errors++; $display("FAIL sw_win1 got=%0d want=16", r0[1]); end
  endtask

  task automatic test_ramp();
    load_x(1);
    load_w(1);
    run_pass(0);
    checks++;
    if (r0[0] !== 22'sd216 || r1[0] !== 22'sd0) begin
      errors++; $display("FAIL ramp_00 got=%0d,%0d want=216,0", r0[0], r1[0]);
    end
    checks++;
    if (r0[1] !== 22'sd232 || r1[1] !== 22'sd1) begin
      errors++; $display("FAIL ramp_01 got=%0d,%0d want=232,1", r0[1], r1[1]);
    end
    checks++;
    if (r0[24] !== 22'sd792 || r1[24] !== 22'sd36) begin
      errors++; $display("FAIL ramp_44 got=%0d,%0d want=792,36", r0[24], r1[24]);
    end
  endtask

  task automatic test_extreme();
    int vb;
    logic signed [AW-1:0] expn;
`ifdef CONV_ENGINE_RELU_EN
    expn = '0;
`else
    expn = -22'sd1044480;
`endif
    load_x(2);
    load_w(2);
    run_pass(0);
    vb = 0;
    for (int i = 0; i < 25; i++)
      if (r0[i] !== 22'sd1048576 || r1[i] !== 22'sd1048576) vb++;
    checks++;
    if (vb != 0) begin errors++; $display("FAIL ext_pos bad=%0d ch0=%0d want=1048576", vb, r0[0]); end
    load_w(3);
    run_pass(0);
    vb = 0;
    for (int i = 0; i < 25; i++)
      if (r0[i] !== expn || r1[i] !== expn) vb++;
    checks++;
    if (vb != 0) begin errors++; $display("FAIL ext_neg bad=%0d ch0=%0d want=%0d", vb, r0[0], expn); end
  endtask

  task automatic test_abort();
    int stray, vb;
    load_x(0);
    load_w(0);
    @(negedge clk);
    start = 1'b1;
    for (int d = 1; d <= 39; d++) begin
      @(negedge clk);
      if (d == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || out_data !== '0 || out_col !== '0) begin
      errors++;
      $display("FAIL abort_clear busy=%b valid=%b done=%b data=%h col=%0d want all 0",
               busy, out_valid, done, out_data, out_col);
    end
    rst = 1'b0;
    stray = 0;
    for (int d = 0; d < 450; d++) begin
      @(negedge clk);
      if (done || out_valid || busy) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL abort_quiet got=%0d want=0", stray); end
    run_pass(0);
    vb = 0;
    for (int i = 0; i < 25; i++)
      if (r0[i] !== 22'sd16 || r1[i] !== 22'sd16) vb++;
    checks++;
    if (vcnt != 25 || done_off != 426 || vb != 0) begin
      errors++; $display("FAIL abort_rerun cnt=%0d done=%0d bad=%0d want 25 426 0", vcnt, done_off, vb);
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2, v2, nv;
    d1 = -1; d2 = -1; v2 = -1; nv = 0;
    @(negedge clk);
    start = 1'b1;
    for (int d = 1; d <= 1000 && d2 < 0; d++) begin
      @(negedge clk);
      if (d1 > 0 && d == d1 + 2) start = 1'b0;
      if (out_valid) begin
        nv++;
        if (d1 > 0 && v2 < 0) v2 = d;
      end
      if (done) begin
        if (d1 < 0) d1 = d;
        else d2 = d;
      end
    end
    start = 1'b0;
    checks++;
    if (d1 != 426 || v2 != 444 || d2 != 853) begin
      errors++; $display("FAIL b2b_timing got=%0d,%0d,%0d want=426,444,853", d1, v2, d2);
    end
    checks++;
    if (nv != 50) begin errors++; $display("FAIL b2b_count got=%0d want=50", nv); end
    @(negedge clk);
  endtask

  task automatic test_small();
    int cnt, vdd, sd;
    logic [AW-1:0] got;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      s_x_we = 1'b1; s_x_addr = 4'(i); s_x_data = 9'sd2;
      s_w_we = 1'b1; s_w_addr = 4'(i); s_w_data = 9'sd3;
    end
    @(negedge clk);
    s_x_we = 1'b0; s_w_we = 1'b0;
    cnt = 0; vdd = -1; sd = -1; got = '0;
    s_start = 1'b1;
    for (int d = 1; d <= 100 && sd < 0; d++) begin
      @(negedge clk);
      if (d == 1) s_start = 1'b0;
      if (s_out_valid) begin cnt++; vdd = d; got = s_out_data; end
      if (s_done) sd = d;
    end
    checks++;
    if (cnt != 1 || vdd != 17) begin
      errors++; $display("FAIL small_valid cnt=%0d at=%0d want 1 at 17", cnt, vdd);
    end
    checks++;
    if (got !== 22'd96) begin errors++; $display("FAIL small_data got=%0d want=96", got); end
    checks++;
    if (sd != 18) begin errors++; $display("FAIL small_done got=%0d want=18", sd); end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_midpass();
    test_start_write();
    test_ramp();
    test_extreme();
    test_abort();
    test_back_to_back();
    test_small();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
